// File: rtl/ae_sequencer.sv
// ae_sequencer: runs fill -> threshold -> acquire -> finish rounds on the AE.
// Optional AE_SEQ_TIMEOUT_EN builds the wait-state timeout and seq_error.
module ae_sequencer #(
  parameter logic [7:0] ADDR_CONTROL        = 8'h00,
  parameter logic [7:0] ADDR_BUFFER_CONTROL = 8'h04
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic [5:0]  cfg_channel_num,
  input  logic [6:0]  cfg_buffer_th,
  input  logic        cfg_init_nco,
  input  logic [3:0]  cfg_rounds,
  input  logic [15:0] cfg_timeout,
  input  logic        host_busy,
  input  logic        fill_start,
  input  logic        ae_buffer_reach_th,
  input  logic        ae_finish,
  output logic        seq_reg_cs,
  output logic        seq_wr,
  output logic [7:0]  seq_addr,
  output logic [31:0] seq_d4wt,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_error,
  output logic [3:0]  round_cnt,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_FILL   = 3'd1,
    S_WAIT_FILL = 3'd2,
    S_WAIT_TH   = 3'd3,
    S_WR_START  = 3'd4,
    S_WAIT_FIN  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_ch;
  logic [6:0]  r_th;
  logic        r_init;
  logic [3:0]  r_rounds;
  logic [3:0]  r_round;
  logic [3:0]  w_round_inc;
  logic        w_last;
  logic        w_start_job;
  logic        w_fin_evt;
  logic        w_expire;

  assign w_start_job = (r_state == S_IDLE) && seq_start && !seq_abort;
  assign w_round_inc = r_round + 4'd1;
  // rounds==0 matches after the 4-bit count wraps 15 -> 0
  assign w_last      = (w_round_inc == r_rounds);
  assign w_fin_evt   = (r_state == S_WAIT_FIN) && ae_finish && !seq_abort;

`ifdef AE_SEQ_TIMEOUT_EN
  logic [15:0] r_cfg_tmo;
  logic [15:0] r_tmo;
  logic        r_err;
  logic        w_wait;
  logic        w_event;
  logic        w_enter_wait;

  assign w_wait  = (r_state == S_WAIT_FILL) ||
                   (r_state == S_WAIT_TH) ||
                   (r_state == S_WAIT_FIN);
  assign w_event = ((r_state == S_WAIT_FILL) && fill_start) ||
                   ((r_state == S_WAIT_TH) && ae_buffer_reach_th) ||
                   ((r_state == S_WAIT_FIN) && ae_finish);
  assign w_enter_wait = (w_state_nxt != r_state) &&
                        ((w_state_nxt == S_WAIT_FILL) ||
                         (w_state_nxt == S_WAIT_TH) ||
                         (w_state_nxt == S_WAIT_FIN));
  // the awaited event beats expiry in the same cycle
  assign w_expire = w_wait && (r_cfg_tmo != 16'd0) &&
                    (r_tmo == 16'd0) && !w_event && !seq_abort;
  assign seq_error = r_err & ~seq_abort;

  // wait-state timeout: reload on entry, count down while waiting
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cfg_tmo <= 16'd0;
      r_tmo     <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_expire;
      if (w_start_job) r_cfg_tmo <= cfg_timeout;
      if (w_enter_wait) r_tmo <= r_cfg_tmo;
      else if (w_wait && (r_tmo != 16'd0)) r_tmo <= r_tmo - 16'd1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^cfg_timeout;
  assign w_expire     = 1'b0;
  assign seq_error    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // job configuration latch and round counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ch     <= 6'd0;
      r_th     <= 7'd0;
      r_init   <= 1'b0;
      r_rounds <= 4'd0;
      r_round  <= 4'd0;
    end else if (w_start_job) begin
      r_ch     <= cfg_channel_num;
      r_th     <= cfg_buffer_th;
      r_init   <= cfg_init_nco;
      r_rounds <= cfg_rounds;
      r_round  <= 4'd0;
    end else if (w_fin_evt) begin
      r_round  <= w_round_inc;
    end
  end

  // next state and register-port writes
  always_comb begin
    w_state_nxt = r_state;
    seq_wr      = 1'b0;
    seq_addr    = 8'h00;
    seq_d4wt    = 32'h0;
    seq_done    = 1'b0;
    if (seq_abort) begin
      w_state_nxt = S_IDLE;
    end else if (w_expire) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seq_start) w_state_nxt = S_WR_FILL;
        end
        S_WR_FILL: begin
          if (!host_busy) begin
            seq_wr      = 1'b1;
            seq_addr    = ADDR_BUFFER_CONTROL;
            seq_d4wt    = {22'h0, r_init & (r_round == 4'd0),
                           1'b1, 1'b0, r_th};
            w_state_nxt = S_WAIT_FILL;
          end
        end
        S_WAIT_FILL: begin
          if (fill_start) w_state_nxt = S_WAIT_TH;
        end
        S_WAIT_TH: begin
          if (ae_buffer_reach_th) w_state_nxt = S_WR_START;
        end
        S_WR_START: begin
          if (!host_busy) begin
            seq_wr      = 1'b1;
            seq_addr    = ADDR_CONTROL;
            seq_d4wt    = {23'h0, 1'b1, 2'b0, r_ch};
            w_state_nxt = S_WAIT_FIN;
          end
        end
        S_WAIT_FIN: begin
          if (ae_finish) w_state_nxt = w_last ? S_DONE : S_WR_FILL;
        end
        S_DONE: begin
          seq_done    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign seq_reg_cs = seq_wr;
  assign seq_busy   = (r_state != S_IDLE);
  assign round_cnt  = r_round;
  assign seq_state  = r_state;

endmodule

// File: tb/tb_ae_sequencer.sv
// tb_ae_sequencer: randomized self-checking bench for ae_sequencer.
// Expected writes come from a per-round model of the job configuration.
module tb_ae_sequencer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        seq_start;
  logic        seq_abort;
  logic [5:0]  cfg_channel_num;
  logic [6:0]  cfg_buffer_th;
  logic        cfg_init_nco;
  logic [3:0]  cfg_rounds;
  logic [15:0] cfg_timeout;
  logic        host_busy;
  logic        fill_start;
  logic        ae_buffer_reach_th;
  logic        ae_finish;
  logic        seq_reg_cs;
  logic        seq_wr;
  logic [7:0]  seq_addr;
  logic [31:0] seq_d4wt;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_error;
  logic [3:0]  round_cnt;
  logic [2:0]  seq_state;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  r;
    int          c;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_q[$];
  int  err_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  ae_sequencer dut (
    .clk(clk), .rst_b(rst_b),
    .seq_start(seq_start), .seq_abort(seq_abort),
    .cfg_channel_num(cfg_channel_num), .cfg_buffer_th(cfg_buffer_th),
    .cfg_init_nco(cfg_init_nco), .cfg_rounds(cfg_rounds),
    .cfg_timeout(cfg_timeout), .host_busy(host_busy),
    .fill_start(fill_start), .ae_buffer_reach_th(ae_buffer_reach_th),
    .ae_finish(ae_finish), .seq_reg_cs(seq_reg_cs), .seq_wr(seq_wr),
    .seq_addr(seq_addr), .seq_d4wt(seq_d4wt), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_error(seq_error), .round_cnt(round_cnt),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  // record writes/pulses mid-cycle; check port rules every cycle
  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      checks++;
      if (seq_reg_cs !== seq_wr) begin
        errors++;
        $display("FAIL cs_eq_wr cyc %0d got %b want %b", cyc, seq_reg_cs, seq_wr);
      end
      if (seq_wr === 1'b1) begin
        got_q.push_back('{a:seq_addr, d:seq_d4wt, r:round_cnt, c:cyc});
      end else begin
        checks++;
        if (seq_addr !== 8'h0 || seq_d4wt !== 32'h0) begin
          errors++;
          $display("FAIL idle_bus cyc %0d got %h/%h want 0/0", cyc, seq_addr, seq_d4wt);
        end
      end
      if (seq_done === 1'b1) done_q.push_back(cyc);
      if (seq_error === 1'b1) err_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_job(input int n, input logic [6:0] th,
                                    input logic [5:0] ch, input bit init);
    wr_t e;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      e.a = 8'h04;
      e.d = 32'h100 + ((init && r == 0) ? 32'h200 : 32'h0) + 32'(th);
      e.r = 4'(r);
      e.c = 0;
      exp_q.push_back(e);
      e.a = 8'h00;
      e.d = 32'h100 + 32'(ch);
      exp_q.push_back(e);
    end
  endfunction

  task automatic pulse_start(input logic [3:0] rounds, input logic [6:0] th,
                             input logic [5:0] ch, input bit init,
                             input logic [15:0] tmo, output int scyc);
    cfg_rounds      = rounds;
    cfg_buffer_th   = th;
    cfg_channel_num = ch;
    cfg_init_nco    = init;
    cfg_timeout     = tmo;
    seq_start       = 1'b1;
    scyc            = cyc;
    tick();
    seq_start       = 1'b0;
    cfg_rounds      = 4'($urandom);
    cfg_buffer_th   = 7'($urandom);
    cfg_channel_num = 6'($urandom);
    cfg_init_nco    = 1'($urandom);
    cfg_timeout     = 16'($urandom_range(1, 3));
  endtask

  task automatic wait_write(input int want, input int busy_pct, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() >= want) begin
        ok = 1'b1;
        host_busy = 1'b0;
        return;
      end
      host_busy = ($urandom_range(99) < busy_pct);
      tick();
    end
    host_busy = 1'b0;
    errors++;
    $display("FAIL wait_write timeout got %0d want %0d writes", got_q.size(), want);
  endtask

  task automatic drive_job(input int n, input int busy_pct, input bit spur,
                           output int last_fin, output bit ok);
    int base;
    base = got_q.size();
    ok = 1'b1;
    last_fin = cyc;
    for (int r = 0; r < n; r++) begin
      wait_write(base + 2 * r + 1, busy_pct, ok);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) tick();
      fill_start = 1'b1;
      ae_finish  = spur;
      tick();
      fill_start = 1'b0;
      ae_finish  = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      ae_buffer_reach_th = 1'b1;
      wait_write(base + 2 * r + 2, busy_pct, ok);
      ae_buffer_reach_th = 1'b0;
      if (!ok) return;
      repeat ($urandom_range(0, 3)) tick();
      ae_finish  = 1'b1;
      fill_start = spur;
      last_fin   = cyc;
      tick();
      ae_finish  = 1'b0;
      fill_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    seq_start = 0; seq_abort = 0; host_busy = 0;
    fill_start = 0; ae_buffer_reach_th = 0; ae_finish = 0;
    cfg_channel_num = 0; cfg_buffer_th = 0; cfg_init_nco = 0;
    cfg_rounds = 0; cfg_timeout = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seq_busy, seq_done, seq_error, seq_wr, seq_reg_cs} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {seq_busy, seq_done, seq_error, seq_wr, seq_reg_cs});
    end
    checks++;
    if (seq_addr !== 8'h0 || seq_d4wt !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h want 0/0", seq_addr, seq_d4wt);
    end
    checks++;
    if (seq_state !== 3'd0 || round_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d want 0/0", seq_state, round_cnt);
    end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int base, s, m;
    bit ok;
    base = got_q.size();
    done_q.delete();
    err_q.delete();
    model_job(2, 7'h20, 6'd5, 1'b1);
    pulse_start(4'd2, 7'h20, 6'd5, 1'b1, 16'd0, s);
    drive_job(2, 0, 1'b0, m, ok);
    @(negedge clk);
    checks++;
    if (seq_done !== 1'b1 || round_cnt !== 4'd2) begin
      errors++;
      $display("FAIL basic_done got %b/%0d want 1/2", seq_done, round_cnt);
    end
    @(negedge clk);
    checks++;
    if (seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_low got %b want 0", seq_busy);
    end
    tick();
    checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base+i].a !== exp_q[i].a || got_q[base+i].d !== exp_q[i].d) begin
          errors++;
          $display("FAIL basic_wr%0d got %h:%h want %h:%h", i, got_q[base+i].a,
                   got_q[base+i].d, exp_q[i].a, exp_q[i].d);
        end
      end
      checks++;
      if (got_q[base].c !== s + 1) begin
        errors++;
        $display("FAIL basic_first_lat got %0d want %0d", got_q[base].c, s + 1);
      end
    end
    checks++;
    if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== m + 1)) begin
      errors++;
      $display("FAIL basic_done_cyc got n=%0d want 1 at %0d", done_q.size(), m + 1);
    end
  endtask

  task automatic test_host_busy();
    int base, s;
    base = got_q.size();
    host_busy = 1'b1;
    pulse_start(4'd1, 7'h33, 6'd9, 1'b0, 16'd0, s);
    tick();
    tick();
    tick();
    host_busy = 1'b0;
    repeat (3) tick();
    checks++;
    if (got_q.size() - base !== 1) begin
      errors++;
      $display("FAIL hb_count got %0d want 1", got_q.size() - base);
    end else begin
      checks++;
      if (got_q[base].c !== s + 4 || got_q[base].d !== 32'h133) begin
        errors++;
        $display("FAIL hb_write got cyc %0d d %h want cyc %0d d 133",
                 got_q[base].c, got_q[base].d, s + 4);
      end
    end
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    tick();
  endtask

  task automatic test_stale_th();
    int base, s;
    bit ok;
    base = got_q.size();
    ae_buffer_reach_th = 1'b1;
    pulse_start(4'd1, 7'h05, 6'd17, 1'b0, 16'd0, s);
    wait_write(base + 1, 0, ok);
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (got_q.size() - base !== 1 || seq_state !== 3'd2) begin
      errors++;
      $display("FAIL stale_th got %0d writes st %0d want 1 st 2",
               got_q.size() - base, seq_state);
    end
    tick();
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    wait_write(base + 2, 0, ok);
    checks++;
    if (!ok || got_q[base+1].a !== 8'h00 || got_q[base+1].d !== 32'h111) begin
      errors++;
      $display("FAIL stale_ctrl got ok=%b want CONTROL 111", ok);
    end
    ae_buffer_reach_th = 1'b0;
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int base, s;
    bit ok;
    base = got_q.size();
    pulse_start(4'd3, 7'h44, 6'd2, 1'b1, 16'd0, s);
    wait_write(base + 1, 0, ok);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (seq_state !== 3'd3) begin
      errors++;
      $display("FAIL abort_in_th got %0d want 3", seq_state);
    end
    tick();
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    @(negedge clk);
    checks++;
    if (seq_state !== 3'd0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got %0d/%b want 0/0", seq_state, seq_busy);
    end
    tick();
    seq_start = 1'b1;
    seq_abort = 1'b1;
    tick();
    seq_start = 1'b0;
    seq_abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fill_start = 1'b1;
      ae_buffer_reach_th = 1'b1;
      ae_finish = 1'b1;
      tick();
    end
    fill_start = 1'b0;
    ae_buffer_reach_th = 1'b0;
    ae_finish = 1'b0;
    @(negedge clk);
    checks++;
    if (got_q.size() - base !== 1 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start got %0d writes busy %b want 1/0",
               got_q.size() - base, seq_busy);
    end
    tick();
    pulse_start(4'd1, 7'h01, 6'd1, 1'b0, 16'd0, s);
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    tick();
    checks++;
    if (got_q.size() - base !== 1 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr_fill got %0d writes busy %b want 1/0",
               got_q.size() - base, seq_busy);
    end
  endtask

  task automatic run_and_compare(input string nm, input int n, input int busy,
                                 input bit spur);
    int base, s, m;
    bit ok;
    logic [6:0] th;
    logic [5:0] ch;
    bit init;
    logic [15:0] tmo;
    th = 7'($urandom);
    ch = 6'($urandom);
    init = 1'($urandom);
`ifdef AE_SEQ_TIMEOUT_EN
    tmo = $urandom_range(1) ? 16'd40 : 16'd0;
`else
    tmo = 16'($urandom);
`endif
    base = got_q.size();
    done_q.delete();
    err_q.delete();
    model_job(n, th, ch, init);
    pulse_start(4'(n), th, ch, init, tmo, s);
    drive_job(n, busy, spur, m, ok);
    @(negedge clk);
    checks++;
    if (seq_done !== 1'b1 || round_cnt !== 4'(n)) begin
      errors++;
      $display("FAIL %s_done got %b/%0d want 1/%0d", nm, seq_done, round_cnt, 4'(n));
    end
    tick();
    tick();
    checks++;
    if (got_q.size() - base !== exp_q.size() || done_q.size() !== 1 ||
        err_q.size() !== 0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_summary got wr %0d done %0d err %0d busy %b want %0d 1 0 0",
               nm, got_q.size() - base, done_q.size(), err_q.size(), seq_busy,
               exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base+i].a !== exp_q[i].a || got_q[base+i].d !== exp_q[i].d ||
            got_q[base+i].r !== exp_q[i].r) begin
          errors++;
          $display("FAIL %s_wr%0d got %h:%h r%0d want %h:%h r%0d", nm, i,
                   got_q[base+i].a, got_q[base+i].d, got_q[base+i].r,
                   exp_q[i].a, exp_q[i].d, exp_q[i].r);
        end
      end
    end
  endtask

  task automatic test_rounds16();
    run_and_compare("r16", 16, 20, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_and_compare("rnd", $urandom_range(1, 5), 30, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int base, s, m;
    bit ok;
    base = got_q.size();
    pulse_start(4'd3, 7'h10, 6'd4, 1'b0, 16'd0, s);
    drive_job(1, 0, 1'b0, m, ok);
    wait_write(base + 3, 0, ok);
    @(negedge clk);
    checks++;
    if (round_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mid_round got %0d want 1", round_cnt);
    end
    tick();
    rst_b = 1'b0;
    #2;
    checks++;
    if (seq_state !== 3'd0 || round_cnt !== 4'd0 || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %0d/%0d/%b want 0/0/0", seq_state, round_cnt, seq_busy);
    end
    tick();
    rst_b = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 6; i++) begin
      fill_start = 1'b1;
      ae_buffer_reach_th = 1'b1;
      ae_finish = 1'b1;
      tick();
    end
    fill_start = 1'b0;
    ae_buffer_reach_th = 1'b0;
    ae_finish = 1'b0;
    checks++;
    if (got_q.size() !== base || seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet got %0d writes busy %b want 0/0",
               got_q.size() - base, seq_busy);
    end
  endtask

`ifdef AE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int base, s, w;
    bit ok;
    base = got_q.size();
    done_q.delete();
    err_q.delete();
    pulse_start(4'd1, 7'h11, 6'd3, 1'b0, 16'd10, s);
    wait_write(base + 1, 0, ok);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    ae_buffer_reach_th = 1'b1;
    wait_write(base + 2, 0, ok);
    ae_buffer_reach_th = 1'b0;
    w = ok ? got_q[base+1].c : 0;
    repeat (20) tick();
    checks++;
    if (err_q.size() !== 1 || (err_q.size() == 1 && err_q[0] !== w + 12) ||
        seq_busy !== 1'b0 || done_q.size() !== 0) begin
      errors++;
      $display("FAIL tmo_error got n=%0d busy %b done %0d want 1 at %0d",
               err_q.size(), seq_busy, done_q.size(), w + 12);
    end
    base = got_q.size();
    err_q.delete();
    pulse_start(4'd1, 7'h12, 6'd6, 1'b0, 16'd3, s);
    wait_write(base + 1, 0, ok);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    ae_buffer_reach_th = 1'b1;
    wait_write(base + 2, 0, ok);
    ae_buffer_reach_th = 1'b0;
    repeat (3) tick();
    ae_finish = 1'b1;
    tick();
    ae_finish = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_q.size() !== 1 || err_q.size() !== 0) begin
      errors++;
      $display("FAIL tmo_event_wins got done %0d err %0d want 1 0",
               done_q.size(), err_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_host_busy();
    test_stale_th();
    test_abort();
    test_rounds16();
    test_random();
    test_reset_mid();
`ifdef AE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ae_sequencer.md
# ae_sequencer

Hardware sequencer for the acquisition engine. It runs the fill → threshold → acquire → finish loop for a programmed number of rounds without per-step host intervention. It issues the AE register writes (buffer control with fill/init-NCO, control with start), and watches the AE sync and status signals. The sequencer sits beside the host bus on the AE register write port; an external mux gives the host priority through `host_busy`.

## Interface
- `ADDR_CONTROL`, default 8'h00: AE control register address.
- `ADDR_BUFFER_CONTROL`, default 8'h04: AE buffer control register address.
- `clk  in  1`: system clock.
- `rst_b  in  1`: reset, asynchronous, active-low.
- `seq_start  in  1`: one-cycle pulse that starts a job.
- `seq_abort  in  1`: one-cycle pulse that aborts the job.
- `cfg_channel_num  in  6`: channel count written to control[5:0].
- `cfg_buffer_th  in  7`: threshold written to buffer control[6:0].
- `cfg_init_nco  in  1`: when set, sets buffer control[9] on round 0 only.
- `cfg_rounds  in  4`: number of rounds; 0 means 16.
- `cfg_timeout  in  16`: wait-state timeout in cycles; 0 disables it.
- `host_busy  in  1`: host owns the AE register port this cycle.
- `fill_start  in  1`: AE fill-start pulse.
- `ae_buffer_reach_th  in  1`: AE buffer threshold level.
- `ae_finish  in  1`: AE finish pulse.
- `seq_reg_cs  out  1`: register chip select, same as `seq_wr`.
- `seq_wr  out  1`: register write strobe.
- `seq_addr  out  8`: register address.
- `seq_d4wt  out  32`: register write data.
- `seq_busy  out  1`: high whenever state ≠ IDLE.
- `seq_done  out  1`: one-cycle pulse at normal completion.
- `seq_error  out  1`: one-cycle pulse on timeout.
- `round_cnt  out  4`: index of the current round.
- `seq_state  out  3`: current state encoding.

## Operation
- States:
  - IDLE=0
  - WR_FILL=1
  - WAIT_FILL=2
  - WAIT_TH=3
  - WR_START=4
  - WAIT_FIN=5
  - DONE=6
- IDLE: on `seq_start`, latch all `cfg_*` inputs, clear `round_cnt`, go to WR_FILL. `seq_start` is ignored in every state other than IDLE.
- WR_FILL: when `host_busy`=0, assert the write.
  - `seq_addr` = `ADDR_BUFFER_CONTROL`.
  - `seq_d4wt` = {22'h0, init, 1'b1, 1'b0, th}, where init = latched `cfg_init_nco` & (`round_cnt`==0).
  - Then go to WAIT_FILL. While `host_busy`=1, hold the state with no write.
- WAIT_FILL: on `fill_start`=1, go to WAIT_TH. Waiting for `fill_start` first keeps a stale `reach_th` level from the previous fill from being taken.
- WAIT_TH: on `ae_buffer_reach_th`=1, go to WR_START.
- WR_START: when `host_busy`=0, assert the write.
  - `seq_addr` = `ADDR_CONTROL`.
  - `seq_d4wt` = {23'h0, 1'b1, 2'b0, ch}.
  - Then go to WAIT_FIN.
- WAIT_FIN: on `ae_finish`=1, increment `round_cnt`.
  - If the incremented count equals the latched rounds (0 counts as 16, so with `cfg_rounds`=0 the 4-bit count wraps from 15 to 0 to match), go to DONE.
  - Otherwise go to WR_FILL.
- DONE: assert `seq_done` for one cycle, then go to IDLE.
- `seq_abort` in any state: go to IDLE next cycle, with no write, no `seq_done` and no `seq_error` that cycle. If `seq_abort` and `seq_start` arrive together in IDLE, abort wins and the job does not start.
- Write outputs are combinational from state and `host_busy`. `seq_addr` and `seq_d4wt` are 0 whenever `seq_wr`=0.
- Pulses arriving outside their wait state are ignored: `fill_start` outside WAIT_FILL, `ae_finish` outside WAIT_FIN.

## Timing
- Reset values:
  - state IDLE and `round_cnt`=0.
  - `seq_busy`, `seq_done`, `seq_error`, `seq_wr`, `seq_reg_cs` all 0.
  - `seq_addr`=0, `seq_d4wt`=0.
- `seq_start` at cycle N gives the first write at cycle N+1 when `host_busy`=0.
- A write state lasts exactly one cycle once `host_busy`=0.
- From `ae_finish` at cycle M:
  - Not the last round: the next WR_FILL write at M+1.
  - Last round: `seq_done` at M+1, `seq_busy` low at M+2.
- Timeout counter:
  - Loaded with the latched `cfg_timeout` on entry to WAIT_FILL, WAIT_TH and WAIT_FIN.
  - Decrements each cycle in a wait state. Reaching 0 before the awaited event gives `seq_error` on the next cycle and a return to IDLE.
  - If the awaited event and expiry happen in the same cycle, the event wins.
- Reset mid-job returns to IDLE immediately; no writes are issued until the next `seq_start`.

## Configuration
- `AE_SEQ_TIMEOUT_EN`
  - Defined: the 16-bit timeout counter and `seq_error` operate as described above.
  - Undefined: no counter is built, `cfg_timeout` is ignored, `seq_error` is tied to 0, and wait states wait indefinitely (only abort or reset exits).

## Test plan
- `cfg_rounds`=2, th=0x20, ch=5, `cfg_init_nco`=1, `host_busy`=0.
  - Required writes in order: BUFFER_CONTROL 0x320, CONTROL 0x105, BUFFER_CONTROL 0x120, CONTROL 0x105.
  - `seq_done` one cycle after the second `ae_finish`.
- `host_busy`=1 for 3 cycles while in WR_FILL → the write is delayed to the cycle `host_busy` drops, and exactly one write is issued.
- `reach_th` held high from a prior job, new start → no CONTROL write before `fill_start` is seen.
- `cfg_timeout`=10, `ae_finish` never arrives (macro defined) → `seq_error` pulse 11 cycles after entering WAIT_FIN, then IDLE, `seq_busy`=0.
- `seq_abort` in WAIT_TH; then `seq_start`+`seq_abort` together in IDLE → back to IDLE with no further writes and no job start.
- `cfg_rounds`=0 → 16 CONTROL writes, then `seq_done`; `round_cnt` wraps from 15 to 0.
